// File: rtl/lsu_mem_port_if.sv
// Bundle of the core-side request/response handshake and the data-memory
// port of the load/store unit. The slave modport is the LSU's view; the
// master modport is the view of whatever sits on the other side (core and
// memory together).
interface lsu_mem_port_if #(
    parameter int ADDR_WIDTH = 8
);
    // Core request: a transfer happens on a rising edge where req_valid and
    // req_ready are both high. req_ready depends only on LSU state, never on
    // req_valid. Request fields are sampled on that edge only. The response
    // is a single-cycle resp_valid strobe qualified by resp_err.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;

    // Data memory: one-cycle request, read data valid the cycle after.
    logic                  mem_request;
    logic                  mem_we_re;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_in;
    logic [3:0]            mem_mask;
    logic [31:0]           mem_data_out;

    // Current FSM state, for observation only.
    logic [1:0]            dbg_state;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
        output dbg_state
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
        input  dbg_state
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit between the execute stage and the 256-word data memory.
// One byte/half/word access per transaction, four cycles each:
// IDLE (accept) -> ISSUE (memory request) -> WAIT (read data back) -> RESP.
// Illegal width codes skip the memory and respond from RESP with resp_err.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses are
// rejected with resp_err instead of being force-aligned.
module lsu_mem_port #(
    parameter int ADDR_WIDTH = 8,
    parameter int XLEN       = 32
) (
    input logic           clk,
    input logic           rst_n,
    lsu_mem_port_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]      state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic            req_legal;
    logic            req_trap;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_result;

    // High address bits alias onto the 256-word memory.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.dbg_state = state;

    // Decode legality of the incoming request's width code.
    always_comb begin
        req_legal = 1'b0;
        if (bus.req_we) begin
            req_legal = (bus.req_funct3[2] == 1'b0) && (bus.req_funct3[1:0] != 2'b11);
        end else begin
            req_legal = !((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                          (bus.req_funct3 == 3'b111));
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Half accesses need an even byte offset, word accesses a zero offset.
    always_comb begin
        req_trap = 1'b0;
        if (bus.req_funct3[1:0] == 2'b01) begin
            req_trap = bus.req_addr[0];
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            req_trap = (bus.req_addr[1:0] != 2'b00);
        end
    end
`else
    // Misaligned accesses are force-aligned instead of rejected.
    always_comb begin
        req_trap = 1'b0;
    end
`endif

    // Store lane enables and lane-replicated write data.
    always_comb begin
        st_mask = 4'b1111;
        st_data = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << bus.req_addr[1:0];
                st_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = bus.req_wdata;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        ld_byte   = bus.mem_data_out[{off_q, 3'b000} +: 8];
        ld_half   = off_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
        ld_result = bus.mem_data_out;
        case (f3_q)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_result = {24'd0, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_result = {16'd0, ld_half};
            default: ld_result = bus.mem_data_out;
        endcase
    end

    // Transaction FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            we_q            <= 1'b0;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            bus.resp_valid  <= 1'b0;
            bus.resp_err    <= 1'b0;
            bus.resp_rdata  <= '0;
            bus.mem_request <= 1'b0;
            bus.mem_we_re   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            bus.mem_mask    <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q  <= bus.req_we;
                        f3_q  <= bus.req_funct3;
                        off_q <= bus.req_addr[1:0];
                        if (!req_legal || req_trap) begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            state           <= ST_ISSUE;
                            bus.mem_request <= 1'b1;
                            bus.mem_we_re   <= bus.req_we;
                            bus.mem_address <= bus.req_addr[ADDR_WIDTH+1:2];
                            bus.mem_mask    <= bus.req_we ? st_mask : 4'b0000;
                            bus.mem_data_in <= bus.req_we ? st_data : '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    bus.mem_request <= 1'b0;
                    state           <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!we_q) begin
                        bus.resp_rdata <= ld_result;
                    end
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    state          <= ST_RESP;
                end
                default: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-addressed reference model, a memory model
// driven by the DUT's port, one per-cycle compare process, and directed
// transactions with hand-computed literal expectations.
module tb_lsu_mem_port;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.ADDR_WIDTH(AW)) bus ();

    lsu_mem_port #(.ADDR_WIDTH(AW), .XLEN(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] word_init(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // ---------------- memory attached to the DUT ----------------
    logic [31:0] ram [256];
    bit          ram_loaded;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= word_init(i);
            ram_loaded <= 1'b1;
        end else if (bus.mem_request) begin
            if (bus.mem_we_re) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_mask[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
            end
            bus.mem_data_out <= ram[bus.mem_address];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_bytes [1024];
    logic [31:0] model_rdata;

    typedef struct {
        int          issue_cyc;
        int          resp_cyc;
        logic        do_issue;
        logic        err;
        logic [31:0] rdata;
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  mask;
        logic [31:0] din;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t predict(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [1:0]  o;
        logic [1:0]  sz;
        logic        legal;
        logic        mis;
        int          base;
        int          a;
        logic [7:0]  b0;
        logic [15:0] h;
        o     = addr[1:0];
        sz    = f3[1:0];
        base  = int'(addr[9:2]) * 4;
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        mis   = (sz == 2'd1 && o[0]) || (sz == 2'd2 && o != 2'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        e.err = !legal || mis;
`else
        e.err = !legal || (mis && 1'b0);
`endif
        e.we        = we;
        e.addr      = addr[9:2];
        e.mask      = 4'b0000;
        e.din       = 32'd0;
        e.do_issue  = !e.err;
        e.issue_cyc = 0;
        e.resp_cyc  = 0;
        if (!e.err && we) begin
            case (sz)
                2'd0: begin
                    e.mask = 4'b0001 << o;
                    e.din  = {4{wdata[7:0]}};
                    ref_bytes[base + int'(o)] = wdata[7:0];
                end
                2'd1: begin
                    a      = o[1] ? 2 : 0;
                    e.mask = o[1] ? 4'b1100 : 4'b0011;
                    e.din  = {2{wdata[15:0]}};
                    ref_bytes[base + a]     = wdata[7:0];
                    ref_bytes[base + a + 1] = wdata[15:8];
                end
                default: begin
                    e.mask = 4'b1111;
                    e.din  = wdata;
                    for (int k = 0; k < 4; k++) ref_bytes[base + k] = wdata[8*k +: 8];
                end
            endcase
        end else if (!e.err) begin
            case (sz)
                2'd0: begin
                    b0 = ref_bytes[base + int'(o)];
                    model_rdata = f3[2] ? {24'd0, b0} : {{24{b0[7]}}, b0};
                end
                2'd1: begin
                    a = o[1] ? 2 : 0;
                    h = {ref_bytes[base + a + 1], ref_bytes[base + a]};
                    model_rdata = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
                end
                default: begin
                    model_rdata = {ref_bytes[base + 3], ref_bytes[base + 2],
                                   ref_bytes[base + 1], ref_bytes[base]};
                end
            endcase
        end
        e.rdata = model_rdata;
        return e;
    endfunction

    // ---------------- compare process ----------------
    int          last_resp_cyc;
    logic        last_resp_err;
    logic [31:0] last_resp_rdata;
    logic [3:0]  last_iss_mask;
    logic [31:0] last_iss_din;
    logic [7:0]  last_iss_addr;
    int          t_acc;

    always @(negedge clk) begin
        if (rst_n && ram_loaded) begin
            if (exp_q.size() > 0 && exp_q[0].do_issue && exp_q[0].issue_cyc == cyc) begin
                check("mem_request", 32'(bus.mem_request), 32'd1);
                check("mem_we_re", 32'(bus.mem_we_re), 32'(exp_q[0].we));
                check("mem_address", 32'(bus.mem_address), 32'(exp_q[0].addr));
                check("mem_mask", 32'(bus.mem_mask), 32'(exp_q[0].mask));
                if (exp_q[0].we) check("mem_data_in", bus.mem_data_in, exp_q[0].din);
                last_iss_mask = bus.mem_mask;
                last_iss_din  = bus.mem_data_in;
                last_iss_addr = bus.mem_address;
            end else begin
                check("mem_request_quiet", 32'(bus.mem_request), 32'd0);
            end
            if (exp_q.size() > 0 && exp_q[0].resp_cyc == cyc) begin
                check("resp_valid", 32'(bus.resp_valid), 32'd1);
                check("resp_err", 32'(bus.resp_err), 32'(exp_q[0].err));
                check("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
                last_resp_cyc   = cyc;
                last_resp_err   = bus.resp_err;
                last_resp_rdata = bus.resp_rdata;
                void'(exp_q.pop_front());
            end else begin
                check("resp_valid_quiet", 32'(bus.resp_valid), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Holds req_valid until n_acc accepts have been seen (ready at a negedge
    // with valid high means the following rising edge accepts).
    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int n_acc,
                         output int first_acc, output int last_acc);
        exp_t e;
        int   got;
        int   waited;
        got       = 0;
        waited    = 0;
        first_acc = -1;
        last_acc  = -1;
        @(negedge clk);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        while (1) begin
            if (bus.req_ready) begin
                e = predict(we, f3, addr, wdata);
                e.issue_cyc = cyc + 1;
                e.resp_cyc  = e.err ? cyc + 1 : cyc + 3;
                exp_q.push_back(e);
                if (got == 0) first_acc = cyc;
                last_acc = cyc;
                got++;
            end
            @(negedge clk);
            waited++;
            if (got == n_acc || waited > 60) break;
        end
        bus.req_valid = 1'b0;
        if (got != n_acc) fail_now("accept");
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            fail_now("response");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
        int a0;
        int a1;
        drive(we, f3, addr, wdata, 1, a0, a1);
        t_acc = a0;
        wait_done();
    endtask

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = word_init(i);
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
        end
        model_rdata    = 32'd0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_request", 32'(bus.mem_request), 32'd0);
        check("rst_mem_we_re", 32'(bus.mem_we_re), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_mem_data_in", bus.mem_data_in, 32'd0);
        check("rst_mem_mask", 32'(bus.mem_mask), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SW / LW round trip.
        txn(1'b1, F_W, 32'h20, 32'hDEADBEEF);
        check("sw_mask", 32'(last_iss_mask), 32'h0000000F);
        check("sw_addr", 32'(last_iss_addr), 32'd8);
        txn(1'b0, F_W, 32'h20, 32'd0);
        check("lw_data", last_resp_rdata, 32'hDEADBEEF);
        check("lw_latency", 32'(last_resp_cyc - t_acc), 32'd3);
        txn(1'b1, F_W, 32'h20, 32'h11223344);
        check("sw_keeps_rdata", last_resp_rdata, 32'hDEADBEEF);

        // Byte store into the top lane, then loads.
        txn(1'b1, F_B, 32'h23, 32'h000000A5);
        check("sb_mask", 32'(last_iss_mask), 32'h00000008);
        check("sb_din", last_iss_din, 32'hA5A5A5A5);
        txn(1'b0, F_B, 32'h23, 32'd0);
        check("lb_data", last_resp_rdata, 32'hFFFFFFA5);
        txn(1'b0, F_BU, 32'h23, 32'd0);
        check("lbu_data", last_resp_rdata, 32'h000000A5);
        txn(1'b0, F_W, 32'h20, 32'd0);
        check("lw_after_sb", last_resp_rdata, 32'hA5223344);

        // Half store to the upper half of word 0x10 (initially 0x13121110).
        txn(1'b1, F_H, 32'h42, 32'h00008001);
        check("sh_mask", 32'(last_iss_mask), 32'h0000000C);
        check("sh_din", last_iss_din, 32'h80018001);
        txn(1'b0, F_H, 32'h42, 32'd0);
        check("lh_data", last_resp_rdata, 32'hFFFF8001);
        txn(1'b0, F_HU, 32'h42, 32'd0);
        check("lhu_data", last_resp_rdata, 32'h00008001);
        txn(1'b1, F_B, 32'h41, 32'h0000007F);
        check("sb1_mask", 32'(last_iss_mask), 32'h00000002);
        txn(1'b0, F_HU, 32'h40, 32'd0);
        check("lhu_low", last_resp_rdata, 32'h00007F10);
        txn(1'b0, F_W, 32'h40, 32'd0);
        check("lw_word10", last_resp_rdata, 32'h80017F10);

        // Misaligned word and half loads.
        txn(1'b0, F_W, 32'h21, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_err", 32'(last_resp_err), 32'd1);
        check("lw_mis_latency", 32'(last_resp_cyc - t_acc), 32'd1);
`else
        check("lw_mis_err", 32'(last_resp_err), 32'd0);
        check("lw_mis_data", last_resp_rdata, 32'hA5223344);
`endif
        txn(1'b0, F_H, 32'h43, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lh_mis_err", 32'(last_resp_err), 32'd1);
`else
        check("lh_mis_data", last_resp_rdata, 32'hFFFF8001);
`endif

        // Illegal codes.
        txn(1'b0, 3'b110, 32'h20, 32'd0);
        check("ld110_err", 32'(last_resp_err), 32'd1);
        txn(1'b1, 3'b100, 32'h20, 32'h000000FF);
        check("st100_err", 32'(last_resp_err), 32'd1);
        check("st100_latency", 32'(last_resp_cyc - t_acc), 32'd1);
        txn(1'b0, F_W, 32'h20, 32'd0);
        check("st100_no_write", last_resp_rdata, 32'hA5223344);

        // req_valid held high: accepted again only on return to IDLE.
        drive(1'b0, 3'b011, 32'h20, 32'd0, 2, a0, a1);
        wait_done();
        check("hold_err_gap", 32'(a1 - a0), 32'd2);
        check("hold_err_flag", 32'(last_resp_err), 32'd1);
        drive(1'b0, F_B, 32'h22, 32'd0, 2, a0, a1);
        wait_done();
        check("hold_ld_gap", 32'(a1 - a0), 32'd4);
        check("hold_ld_data", last_resp_rdata, 32'h00000022);

        // Reset during ISSUE of a store to word 4.
        @(negedge clk);
        bus.req_we     = 1'b1;
        bus.req_funct3 = F_W;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h12345678;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_issue_pre", 32'(bus.mem_request), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_issue_drop", 32'(bus.mem_request), 32'd0);
        check("rst_issue_ready", 32'(bus.req_ready), 32'd1);
        check("rst_issue_mask", 32'(bus.mem_mask), 32'd0);
        check("rst_issue_rdata", bus.resp_rdata, 32'd0);
        model_rdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_word4_kept", ram[4], 32'h07060504);
        check("rst_ready_after", 32'(bus.req_ready), 32'd1);
        txn(1'b0, F_W, 32'h10, 32'd0);
        check("rst_lw_word4", last_resp_rdata, 32'h07060504);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
